gpio_pad_seq: RTL
=================

Name: gpio_pad_seq

Overview:
Per-pad sequencer for the 1.8V GPIO pad cell. It owns every pad control pin: OE/IE, drive strength, slew, open-drain, pulls and Schmitt enable. It performs break-before-make direction turnarounds, shadows the pad configuration, and synchronises and debounces the pad receiver. It sits between the core-side GPIO register block and the pad instance, one instance per pad.

Parameters:
TURN_CYC, 4, cycles spent with both OE and IE low during any direction change; legal range 1..255.
DEB_W, 8, width of the debounce length input and its counter.

Ports:
CLK_I  in  1  core clock.
RST_I  in  1  synchronous, active-high reset.
DIR_REQ_I  in  1  requested direction level: 1 = output, 0 = input.
DOUT_I  in  1  data to drive when in output.
CFG_LD_I  in  1  one-cycle pulse that loads the CFG_* inputs into the shadow registers.
CFG_DS_I  in  4  drive strength.
CFG_SR_I  in  1  slew rate.
CFG_OD_I  in  2  {ODP, ODN}.
CFG_PULL_I  in  2  {PU, PD}.
CFG_STE_I  in  2  Schmitt enable.
DEB_LEN_I  in  DEB_W  debounce length in cycles; 0 = bypass.
DIR_O  out  1  current stable direction.
BUSY_O  out  1  turnaround in progress.
DIR_ACK_O  out  1  one-cycle pulse on completion of a turnaround.
CFG_ERR_O  out  1  one-cycle pulse when CFG_LD_I is rejected.
DIN_O  out  1  debounced pad input.
DIN_EDGE_O  out  1  one-cycle pulse when DIN_O changes.
PAD_DO_O, PAD_SR_O, PAD_OE_O, PAD_ODP_O, PAD_ODN_O, PAD_IE_O, PAD_PU_O, PAD_PD_O  out  1 each  pad controls.
PAD_DS_O  out  4  pad drive strength.
PAD_STE_O  out  2  pad Schmitt enable.
PAD_DI_I  in  2  pad receiver; only bit 0 is used.

Behaviour:
- FSM states: IN, TURN_OUT, OUT, TURN_IN. All pad outputs are registered (Moore decode from state plus shadow registers).
- Reset:
  - State = IN.
  - Shadow registers: DS = 4'b0001, SR = 0, OD = 2'b00, PULL = 2'b00, STE = 2'b00.
  - Turnaround counter = 0, debounce counter = 0.
  - Synchroniser flops = 0, DIN_O = 0.
  - All flag outputs = 0; DIR_O = 0; PAD_OE_O = 0.
  - PAD_IE_O = 1 from the first cycle after reset.
  - Reset mid-turnaround aborts to these values with no ACK.
- Per-state pad controls:
  - IN: OE = 0, IE = 1, PU/PD = shadow.
  - TURN_OUT: OE = 0, IE = 0, PU/PD = 0.
  - OUT: OE = 1, IE = 1 (readback), PU/PD = 0.
  - TURN_IN: OE = 0, IE = 0, PU/PD = shadow.
  - DS, SR, ODP, ODN and STE always come from shadow.
- PAD_DO_O = DOUT_I registered in OUT; 0 in all other states.
- IN -> TURN_OUT when DIR_REQ_I = 1 is sampled. OUT -> TURN_IN when DIR_REQ_I = 0 is sampled.
- Turnaround timing: the FSM stays in TURN_* exactly TURN_CYC cycles, then enters the target state.
  - DIR_ACK_O pulses in the first cycle of the target state.
  - DIR_O updates in that same cycle.
  - BUSY_O = 1 throughout TURN_*.
- If DIR_REQ_I changes during a turnaround, the turnaround still completes and ACKs. The new level is evaluated in the first stable cycle, which may start the reverse turnaround immediately.
- Configuration load:
  - CFG_LD_I is accepted only in state IN; shadow registers update on the next edge.
  - In any other state CFG_LD_I is ignored and CFG_ERR_O pulses for one cycle.
- Input path:
  - PAD_DI_I[0] passes through 2 synchroniser flops.
  - Debounce counter increments while sync != DIN_O and clears when they are equal.
  - When the count reaches DEB_LEN_I, DIN_O takes sync and the counter clears. DIN_EDGE_O pulses in the same cycle.
  - DEB_LEN_I = 0: DIN_O follows sync with 1 cycle of latency.
  - While PAD_IE_O = 0: counter held at 0, DIN_O holds, synchroniser still clocks.
  - Counter saturates and never wraps.

Test Plan:
- Reset: assert RST_I 3 cycles -> OE = 0, DS = 0001, DIN_O = 0, flags 0; IE = 1 on the first cycle after release.
- TURN_CYC = 4, DIR_REQ_I 0->1 sampled at edge k -> IE low from k; OE high and ACK pulse at k+4; BUSY_O high for cycles k..k+3; PAD_DO_O tracks DOUT_I with 1-cycle lag.
- OUT->IN with CFG_PULL = 10 -> PU = 0 in OUT, PU = 1 from TURN_IN entry; IE = 1 and DIR_O = 0 after 4 cycles.
- DEB_LEN = 3: a 2-cycle high glitch on PAD_DI_I[0] -> DIN_O stays 0. A 5-cycle high -> DIN_O = 1 plus one DIN_EDGE_O pulse, 2 sync + 3 cycles after the rise.
- CFG_LD_I in OUT with DS = 1111 -> CFG_ERR_O pulse, PAD_DS_O unchanged. The same load in IN -> PAD_DS_O = 1111 next cycle.
- Assert RST_I in TURN_OUT cycle 2 -> reset values, no ACK. DIR_REQ_I toggled mid-turnaround -> ACK, then an immediate reverse turnaround.

Source files
------------

// File: rtl/gpio_pad_seq_if.sv
// gpio_pad_seq_if: the signal bundle between the core-side GPIO register
// block, the per-pad sequencer and the pad cell.
//   slave  : the sequencer's view. Core requests, config and the pad
//            receiver are inputs. Status flags and pad controls are outputs.
//   master : the driving side's view (register block / pad model).
// DEB_W sets the width of the debounce length field.
interface gpio_pad_seq_if #(parameter int DEB_W = 8);
  logic             DIR_REQ_I;
  logic             DOUT_I;
  logic             CFG_LD_I;
  logic [3:0]       CFG_DS_I;
  logic             CFG_SR_I;
  logic [1:0]       CFG_OD_I;
  logic [1:0]       CFG_PULL_I;
  logic [1:0]       CFG_STE_I;
  logic [DEB_W-1:0] DEB_LEN_I;
  logic             DIR_O;
  logic             BUSY_O;
  logic             DIR_ACK_O;
  logic             CFG_ERR_O;
  logic             DIN_O;
  logic             DIN_EDGE_O;
  logic             PAD_DO_O;
  logic             PAD_SR_O;
  logic             PAD_OE_O;
  logic             PAD_ODP_O;
  logic             PAD_ODN_O;
  logic             PAD_IE_O;
  logic             PAD_PU_O;
  logic             PAD_PD_O;
  logic [3:0]       PAD_DS_O;
  logic [1:0]       PAD_STE_O;
  logic [1:0]       PAD_DI_I;

  modport slave (
    input  DIR_REQ_I, DOUT_I, CFG_LD_I, CFG_DS_I, CFG_SR_I, CFG_OD_I,
           CFG_PULL_I, CFG_STE_I, DEB_LEN_I, PAD_DI_I,
    output DIR_O, BUSY_O, DIR_ACK_O, CFG_ERR_O, DIN_O, DIN_EDGE_O,
           PAD_DO_O, PAD_SR_O, PAD_OE_O, PAD_ODP_O, PAD_ODN_O, PAD_IE_O,
           PAD_PU_O, PAD_PD_O, PAD_DS_O, PAD_STE_O
  );

  modport master (
    output DIR_REQ_I, DOUT_I, CFG_LD_I, CFG_DS_I, CFG_SR_I, CFG_OD_I,
           CFG_PULL_I, CFG_STE_I, DEB_LEN_I, PAD_DI_I,
    input  DIR_O, BUSY_O, DIR_ACK_O, CFG_ERR_O, DIN_O, DIN_EDGE_O,
           PAD_DO_O, PAD_SR_O, PAD_OE_O, PAD_ODP_O, PAD_ODN_O, PAD_IE_O,
           PAD_PU_O, PAD_PD_O, PAD_DS_O, PAD_STE_O
  );
endinterface

// File: rtl/gpio_pad_seq.sv
// gpio_pad_seq: per-pad sequencer for the 1.8V GPIO pad cell.
// It performs break-before-make direction turnarounds (OE and IE both low
// for TURN_CYC cycles), shadows the pad configuration (loadable only while
// in input), and synchronises and debounces the pad receiver.
// Ports:
//   CLK_I, RST_I : clock and synchronous active-high reset
//   bus (slave)  : core requests/config, status flags, pad controls,
//                  pad receiver
// All pad controls and flags come straight from flops. They are decoded
// from the next state so that they line up with the state register.
module gpio_pad_seq #(
  parameter int TURN_CYC = 4,
  parameter int DEB_W    = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  gpio_pad_seq_if.slave bus
);

  typedef enum logic [1:0] {ST_IN, ST_TURN_OUT, ST_OUT, ST_TURN_IN} state_t;

  localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);

  state_t           state_q, state_d;
  logic [7:0]       turn_cnt_q, turn_cnt_d;
  logic [3:0]       ds_q, ds_d;
  logic             sr_q, sr_d;
  logic [1:0]       od_q, od_d, pull_q, pull_d, ste_q, ste_d;
  logic             dir_q, dir_d, busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic             pad_do_q, pad_do_d, pad_oe_q, pad_oe_d, pad_ie_q, pad_ie_d;
  logic             pad_pu_q, pad_pu_d, pad_pd_q, pad_pd_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             din_q, din_d, edge_q, edge_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DEB_W:0]   deb_cnt_inc;
  logic             unused_di1;

  // This pad type only has a single receiver bit.
  assign unused_di1 = bus.PAD_DI_I[1];

  // Direction FSM. A turnaround always runs to completion; the request
  // level is only looked at again once a stable state has been reached.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    ack_d      = 1'b0;
    case (state_q)
      ST_IN: if (bus.DIR_REQ_I) begin
        state_d    = ST_TURN_OUT;
        turn_cnt_d = '0;
      end
      ST_OUT: if (!bus.DIR_REQ_I) begin
        state_d    = ST_TURN_IN;
        turn_cnt_d = '0;
      end
      ST_TURN_OUT: if (turn_cnt_q == TURN_LAST) begin
        state_d    = ST_OUT;
        turn_cnt_d = '0;
        ack_d      = 1'b1;
      end else begin
        turn_cnt_d = turn_cnt_q + 8'd1;
      end
      default: if (turn_cnt_q == TURN_LAST) begin
        state_d    = ST_IN;
        turn_cnt_d = '0;
        ack_d      = 1'b1;
      end else begin
        turn_cnt_d = turn_cnt_q + 8'd1;
      end
    endcase
  end

  // Shadow configuration is only writable while the pad is a stable input.
  always_comb begin
    ds_d   = ds_q;
    sr_d   = sr_q;
    od_d   = od_q;
    pull_d = pull_q;
    ste_d  = ste_q;
    err_d  = 1'b0;
    if (bus.CFG_LD_I) begin
      if (state_q == ST_IN) begin
        ds_d   = bus.CFG_DS_I;
        sr_d   = bus.CFG_SR_I;
        od_d   = bus.CFG_OD_I;
        pull_d = bus.CFG_PULL_I;
        ste_d  = bus.CFG_STE_I;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Pad control decode. Pulls stay off while heading into or sitting in
  // output, so they never fight the driver.
  always_comb begin
    dir_d = dir_q;
    if (state_d == ST_IN)  dir_d = 1'b0;
    if (state_d == ST_OUT) dir_d = 1'b1;
    busy_d   = (state_d == ST_TURN_OUT) || (state_d == ST_TURN_IN);
    pad_oe_d = (state_d == ST_OUT);
    pad_ie_d = (state_d == ST_IN) || (state_d == ST_OUT);
    pad_pu_d = ((state_d == ST_IN) || (state_d == ST_TURN_IN)) && pull_d[1];
    pad_pd_d = ((state_d == ST_IN) || (state_d == ST_TURN_IN)) && pull_d[0];
    pad_do_d = (state_d == ST_OUT) ? bus.DOUT_I : 1'b0;
  end

  // Receiver path. The debounce counter is frozen at zero while the
  // receiver is disabled, so turnaround garbage never reaches DIN_O.
  // The update test uses count+1 so that a length of 0 or 1 means one
  // cycle of latency after the synchroniser.
  always_comb begin
    sync1_d     = bus.PAD_DI_I[0];
    sync2_d     = sync1_q;
    din_d       = din_q;
    edge_d      = 1'b0;
    deb_cnt_d   = deb_cnt_q;
    deb_cnt_inc = {1'b0, deb_cnt_q} + {{DEB_W{1'b0}}, 1'b1};
    if (!pad_ie_q || (sync2_q == din_q)) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_inc >= {1'b0, bus.DEB_LEN_I}) begin
      din_d     = sync2_q;
      edge_d    = 1'b1;
      deb_cnt_d = '0;
    end else if (deb_cnt_q != {DEB_W{1'b1}}) begin
      deb_cnt_d = deb_cnt_inc[DEB_W-1:0];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= ST_IN;
      turn_cnt_q <= '0;
      ds_q       <= 4'b0001;
      sr_q       <= 1'b0;
      od_q       <= 2'b00;
      pull_q     <= 2'b00;
      ste_q      <= 2'b00;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      pad_do_q   <= 1'b0;
      pad_oe_q   <= 1'b0;
      pad_ie_q   <= 1'b1;
      pad_pu_q   <= 1'b0;
      pad_pd_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      din_q      <= 1'b0;
      edge_q     <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      ds_q       <= ds_d;
      sr_q       <= sr_d;
      od_q       <= od_d;
      pull_q     <= pull_d;
      ste_q      <= ste_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      pad_do_q   <= pad_do_d;
      pad_oe_q   <= pad_oe_d;
      pad_ie_q   <= pad_ie_d;
      pad_pu_q   <= pad_pu_d;
      pad_pd_q   <= pad_pd_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      din_q      <= din_d;
      edge_q     <= edge_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  assign bus.DIR_O      = dir_q;
  assign bus.BUSY_O     = busy_q;
  assign bus.DIR_ACK_O  = ack_q;
  assign bus.CFG_ERR_O  = err_q;
  assign bus.DIN_O      = din_q;
  assign bus.DIN_EDGE_O = edge_q;
  assign bus.PAD_DO_O   = pad_do_q;
  assign bus.PAD_OE_O   = pad_oe_q;
  assign bus.PAD_IE_O   = pad_ie_q;
  assign bus.PAD_PU_O   = pad_pu_q;
  assign bus.PAD_PD_O   = pad_pd_q;
  assign bus.PAD_SR_O   = sr_q;
  assign bus.PAD_ODP_O  = od_q[1];
  assign bus.PAD_ODN_O  = od_q[0];
  assign bus.PAD_DS_O   = ds_q;
  assign bus.PAD_STE_O  = ste_q;

endmodule
